// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder made of full-adder cells.
module nibble_adder
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign co = c_s[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per cycle through a single 4-bit adder.
// Optional ovf output (two's-complement overflow) under NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                       cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t                state_r;
    state_t                state_next_s;
    logic [KW-1:0]         k_r;
    logic                  carry_r;
    logic [W-1:0]          a_r;
    logic [W-1:0]          b_r;
    logic [W-1:0]          sum_r;
    logic                  cout_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [NIBBLE_W-1:0]   a_nib_s;
    logic [NIBBLE_W-1:0]   b_nib_s;
    logic [NIBBLE_W-1:0]   s_nib_s;
    logic                  co_nib_s;
    logic                  last_s;

    assign a_nib_s = a_r[k_r*NIBBLE_W +: NIBBLE_W];
    assign b_nib_s = b_r[k_r*NIBBLE_W +: NIBBLE_W];
    assign last_s  = (k_r == K_LAST);

    nibble_adder u_nibble_adder (
        .a  (a_nib_s),
        .b  (b_nib_s),
        .ci (carry_r),
        .s  (s_nib_s),
        .co (co_nib_s)
    );

    // Next-state logic; DONE always passes through IDLE before a new acceptance.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand capture and nibble-by-nibble accumulation into sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            k_r     <= '0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        k_r     <= '0;
                    end
                end
                BUSY: begin
                    sum_r[k_r*NIBBLE_W +: NIBBLE_W] <= s_nib_s;
                    carry_r <= co_nib_s;
                    if (last_s) begin
                        k_r    <= '0;
                        cout_r <= co_nib_s;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Overflow is the carry into the MSB (recovered as a^b^s) against the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state_r == BUSY && last_s) begin
            ovf_r <= a_nib_s[NIBBLE_W-1] ^ b_nib_s[NIBBLE_W-1] ^ s_nib_s[NIBBLE_W-1] ^ co_nib_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against an arithmetic model.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, no nibble decomposition.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("idle_wait", (guard < 20), 1'b1);
        a_in     = av;
        b_in     = bv;
        cin      = cv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges after acceptance until out_valid is seen.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, N);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rdy_after"}, in_ready, 1'b1);
        check({tag, "_vld_after"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, hold_sum;
        logic         rc, hold_cout;
        logic [W:0]   exp;
        logic [W-1:0] q_sum[$];
        logic         q_cout[$];
        int           last_out, n_out;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Carry ripples through every nibble.
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ffff");
        check("ffff_sum", sum, 16'h0000);
        check("ffff_cout", cout, 1'b1);
        finish_op("ffff");

        // Operands and stray in_valid during BUSY must not matter.
        start_op(16'h1234, 16'h4321, 1'b1);
        a_in = 16'hDEAD; b_in = 16'hBEEF; cin = 1'b0; in_valid = 1'b1;
        wait_done("chg");
        in_valid = 1'b0;
        check("chg_sum", sum, 16'h5556);
        check("chg_cout", cout, 1'b0);

        // Stall in DONE with out_ready low and a new request pending.
        hold_sum = sum; hold_cout = cout;
        in_valid = 1'b1; a_in = 16'h0F0F; b_in = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_sum", sum, hold_sum);
            check("stall_cout", cout, hold_cout);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        finish_op("stall");

        // Reset in the second BUSY cycle aborts the operation.
        start_op(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_sum", sum, 16'h0000);
        check("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(16'h0005, 16'h0003, 1'b0);
        wait_done("post_rst");
        check("post_rst_sum", sum, 16'h0008);
        check("post_rst_cout", cout, 1'b0);
        finish_op("post_rst");

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done("ovf1");
        check("ovf1_sum", sum, 16'h8000);
        check("ovf1_ovf", ovf, 1'b1);
        check("ovf1_cout", cout, 1'b0);
        finish_op("ovf1");
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ovf0");
        check("ovf0_ovf", ovf, 1'b0);
        check("ovf0_cout", cout, 1'b1);
        finish_op("ovf0");
`endif

        // Random operations against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = model_add(ra, rb, rc);
            start_op(ra, rb, rc);
            a_in = W'($urandom); b_in = W'($urandom);
            wait_done("rnd");
            check("rnd_sum", sum, exp[W-1:0]);
            check("rnd_cout", cout, exp[W]);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            check("rnd_ovf", ovf, model_ovf(ra, rb, exp[W-1:0]));
`endif
            finish_op("rnd");
        end

        // Back-to-back with both handshakes held high: one result per N+2 cycles.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_out  = -1;
        n_out     = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                if (q_sum.size() > 0) begin
                    check("b2b_sum", sum, q_sum.pop_front());
                    check("b2b_cout", cout, q_cout.pop_front());
                end else begin
                    check("b2b_unexpected", 1'b1, 1'b0);
                end
                if (last_out >= 0) begin
                    check("b2b_gap", cyc - last_out, N + 2);
                end
                last_out = cyc;
                n_out++;
            end
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            a_in = ra; b_in = rb; cin = rc;
            if (in_ready) begin
                exp = model_add(ra, rb, rc);
                q_sum.push_back(exp[W-1:0]);
                q_cout.push_back(exp[W]);
            end
            @(negedge clk);
        end
        check("b2b_count", n_out, 6);
        in_valid = 1'b0;
        repeat (N + 3) @(negedge clk);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
